// File: rtl/srec_loader_if.sv
// Bus bundle for srec_loader: UART byte strobe in, byte-lane memory
// write port out, plus boot status (busy/done/entry/error).
// master = the loader itself, slave = the surrounding SoC side.
interface srec_loader_if #(
    parameter int ADDR_W = 32
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_we;
    logic              mem_ack;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] entry_addr;
    logic              err;
    logic [2:0]        err_code;

    modport master (
        input  rx_valid, rx_data, mem_ack,
        output mem_addr, mem_wdata, mem_be, mem_we,
        output busy, done, entry_addr, err, err_code
    );

    modport slave (
        output rx_valid, rx_data, mem_ack,
        input  mem_addr, mem_wdata, mem_be, mem_we,
        input  busy, done, entry_addr, err, err_code
    );
endinterface

// File: rtl/srec_loader.sv
// Motorola S-record loader: parses the ASCII stream from the UART and
// issues one byte-lane write per data byte of S1/S2/S3 records.
// Optional: define SREC_CHECKSUM_EN to compare record checksums
// (error 2 on mismatch); otherwise checksum chars are only hex-checked.
//
// state | meaning
// IDLE  | waiting for 'S'
// TYPE  | expecting record type digit
// COUNT | two hex chars of the byte count
// ADDR  | 2*AL hex chars of address, MSB first
// DATA  | 2*DL hex chars of payload
// WRITE | mem_we high, waiting for mem_ack
// CKSUM | two hex chars of checksum
module srec_loader #(
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    srec_loader_if.master bus
);
    typedef enum logic [2:0] {IDLE, TYPE, COUNT, ADDR, DATA, WRITE, CKSUM} state_t;
    state_t state, state_nx;

    logic [3:0]        rec_type;
    logic [2:0]        al;
    logic [7:0]        cnt;
    logic [7:0]        bytes_left;
    logic [3:0]        nib_hi;
    logic              nib_phase;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data_byte;
    logic              ovr;
    logic [ADDR_W-1:0] entry_addr;
    logic              done;
    logic [2:0]        err_code;

    logic              nib_ok;
    logic [3:0]        nib_val;
    logic              type_ok;
    logic [2:0]        type_al;
    logic              hex_state;
    logic              byte_done;
    logic [7:0]        full_byte;
    logic [7:0]        min_cnt;
    logic [7:0]        dl;
    logic              rec_data;
    logic              rec_term;
    logic              cnt_bad;
    logic              cks_bad;
    logic              err_set;
    logic [2:0]        err_val;

    assign hex_state = (state == COUNT) || (state == ADDR) || (state == DATA) || (state == CKSUM);
    assign byte_done = hex_state && bus.rx_valid && nib_ok && nib_phase;
    assign full_byte = {nib_hi, nib_val};
    assign min_cnt   = 8'(al) + 8'd1;
    assign dl        = cnt - min_cnt;
    assign rec_data  = (rec_type == 4'd1) || (rec_type == 4'd2) || (rec_type == 4'd3);
    assign rec_term  = (rec_type == 4'd7) || (rec_type == 4'd8) || (rec_type == 4'd9);
    // Termination records must carry no data, so their count is exactly AL+1.
    assign cnt_bad   = (full_byte < min_cnt) || (rec_term && (full_byte != min_cnt));

    // ASCII hex character to nibble
    always_comb begin
        nib_ok  = 1'b1;
        nib_val = 4'd0;
        if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39)
            nib_val = bus.rx_data[3:0];
        else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
                 (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66))
            nib_val = bus.rx_data[3:0] + 4'd9;
        else
            nib_ok = 1'b0;
    end

    // Record type digit to address length; S0 uses a 2-byte address
    always_comb begin
        type_ok = 1'b1;
        type_al = 3'd2;
        case (bus.rx_data)
            8'h30, 8'h31, 8'h39:        type_al = 3'd2;
            8'h32, 8'h38:               type_al = 3'd3;
            8'h33, 8'h35, 8'h36, 8'h37: type_al = 3'd4;
            default:                    type_ok = 1'b0;
        endcase
    end

`ifdef SREC_CHECKSUM_EN
    logic [7:0] sum;
    assign cks_bad = (full_byte != ~sum);

    // Running sum of count, address and data bytes
    always_ff @(posedge clk) begin
        if (reset)
            sum <= 8'd0;
        else if (byte_done && state == COUNT)
            sum <= full_byte;
        else if (byte_done && (state == ADDR || state == DATA))
            sum <= sum + full_byte;
    end
`else
    assign cks_bad = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state and error detection
    always_comb begin
        state_nx = state;
        err_set  = 1'b0;
        err_val  = 3'd0;
        case (state)
            IDLE: if (bus.rx_valid && bus.rx_data == 8'h53) state_nx = TYPE;
            TYPE: begin
                if (bus.rx_valid) begin
                    if (type_ok) begin
                        state_nx = COUNT;
                    end else begin
                        err_set  = 1'b1;
                        err_val  = 3'd5;
                        state_nx = IDLE;
                    end
                end
            end
            COUNT, ADDR, DATA, CKSUM: begin
                if (bus.rx_valid && !nib_ok) begin
                    err_set  = 1'b1;
                    err_val  = 3'd1;
                    state_nx = IDLE;
                end else if (byte_done) begin
                    case (state)
                        COUNT: begin
                            if (cnt_bad) begin
                                err_set  = 1'b1;
                                err_val  = 3'd3;
                                state_nx = IDLE;
                            end else begin
                                state_nx = ADDR;
                            end
                        end
                        ADDR: if (bytes_left == 8'd1) state_nx = (dl == 8'd0) ? CKSUM : DATA;
                        DATA: begin
                            if (rec_data)
                                state_nx = WRITE;
                            else if (bytes_left == 8'd1)
                                state_nx = CKSUM;
                        end
                        default: begin
                            if (cks_bad) begin
                                err_set = 1'b1;
                                err_val = 3'd2;
                            end
                            state_nx = IDLE;
                        end
                    endcase
                end
            end
            WRITE: begin
                if (bus.rx_valid) begin
                    err_set = 1'b1;
                    err_val = 3'd4;
                end
                // An overrun still lets the pending write finish before abandoning.
                if (bus.mem_ack)
                    state_nx = (ovr || bus.rx_valid) ? IDLE : ((bytes_left == 8'd0) ? CKSUM : DATA);
            end
            default: state_nx = IDLE;
        endcase
    end

    // Field assembly, address counter, error latch and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            rec_type   <= 4'd0;
            al         <= 3'd0;
            cnt        <= 8'd0;
            bytes_left <= 8'd0;
            nib_hi     <= 4'd0;
            nib_phase  <= 1'b0;
            addr       <= '0;
            data_byte  <= 8'd0;
            ovr        <= 1'b0;
            entry_addr <= '0;
            done       <= 1'b0;
            err_code   <= 3'd0;
        end else begin
            done <= 1'b0;
            if (err_set && err_code == 3'd0)
                err_code <= err_val;
            if (state_nx == IDLE || state == TYPE)
                nib_phase <= 1'b0;
            else if (hex_state && bus.rx_valid && nib_ok)
                nib_phase <= ~nib_phase;
            if (hex_state && bus.rx_valid && nib_ok && !nib_phase)
                nib_hi <= nib_val;
            if (state == TYPE && bus.rx_valid) begin
                rec_type <= bus.rx_data[3:0];
                al       <= type_al;
            end
            if (byte_done) begin
                case (state)
                    COUNT: begin
                        cnt        <= full_byte;
                        bytes_left <= 8'(al);
                        addr       <= '0;
                    end
                    ADDR: begin
                        addr       <= (addr << 8) | ADDR_W'(full_byte);
                        bytes_left <= (bytes_left == 8'd1) ? dl : bytes_left - 8'd1;
                    end
                    DATA: begin
                        data_byte  <= full_byte;
                        bytes_left <= bytes_left - 8'd1;
                    end
                    CKSUM: begin
                        if (!cks_bad && rec_term) begin
                            entry_addr <= addr;
                            done       <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (state == WRITE) begin
                if (bus.rx_valid)
                    ovr <= 1'b1;
                if (bus.mem_ack) begin
                    addr <= addr + 1'b1;
                    ovr  <= 1'b0;
                end
            end
        end
    end

    assign bus.mem_we     = (state == WRITE);
    assign bus.mem_addr   = addr & ~ADDR_W'(3);
    assign bus.mem_be     = (state == WRITE) ? (4'b0001 << addr[1:0]) : 4'b0000;
    assign bus.mem_wdata  = {4{data_byte}};
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done;
    assign bus.entry_addr = entry_addr;
    assign bus.err        = (err_code != 3'd0);
    assign bus.err_code   = err_code;
endmodule
